// File: rtl/data_stack.sv
// Operand stack for the stack-processor datapath: WIDTH-bit words, DEPTH entries,
// TOS/NOS decoded from registered state, sticky overflow/underflow flags.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    sp_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             empty_s;
    logic             full_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    nos_idx_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [CW-1:0]    sp_nxt_s;
    logic             ovf_set_s;
    logic             unf_set_s;

    // Status decode and entry addressing from the stack pointer alone.
    always_comb begin
        empty_s   = (sp_r == CW'(0));
        full_s    = (sp_r == CW'(DEPTH));
        top_idx_s = AW'(sp_r - CW'(1));
        nos_idx_s = AW'(sp_r - CW'(2));
    end

    // Request decode; full/empty guards keep sp inside 0..DEPTH.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = AW'(sp_r);
        sp_nxt_s  = sp_r;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        case ({push, pop})
            2'b11: begin
                if (empty_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = AW'(0);
                    sp_nxt_s = CW'(1);
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end
            end
            2'b10: begin
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = AW'(sp_r);
                    sp_nxt_s = sp_r + CW'(1);
                end
            end
            2'b01: begin
                if (empty_s) begin
                    unf_set_s = 1'b1;
                end else begin
                    sp_nxt_s = sp_r - CW'(1);
                end
            end
            default: begin
                sp_nxt_s = sp_r;
            end
        endcase
    end

    // Pointer and sticky error flags; a same-cycle error beats clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r        <= CW'(0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            sp_r        <= sp_nxt_s;
            overflow_r  <= ovf_set_s | (overflow_r & ~clr_err);
            underflow_r <= unf_set_s | (underflow_r & ~clr_err);
        end
    end

    // Storage write; contents need no reset since invalid entries are masked.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    // Output view: invalid TOS/NOS read as zero.
    always_comb begin
        tos       = empty_s ? {WIDTH{1'b0}} : mem_r[top_idx_s];
        nos       = (sp_r >= CW'(2)) ? mem_r[nos_idx_s] : {WIDTH{1'b0}};
        count     = sp_r;
        empty     = empty_s;
        full      = full_s;
        overflow  = overflow_r;
        underflow = underflow_r;
    end

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic             m_ovf;
    logic             m_unf;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .clr_err(clr_err), .tos(tos), .nos(nos), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_update(input logic p, input logic q, input logic [WIDTH-1:0] d,
                                         input logic c, input logic r);
        logic e_o, e_u;
        e_o = 1'b0;
        e_u = 1'b0;
        if (r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && q) begin
                if (model_q.size() > 0) model_q[model_q.size()-1] = d;
                else model_q.push_back(d);
            end else if (p) begin
                if (model_q.size() == DEPTH) e_o = 1'b1;
                else model_q.push_back(d);
            end else if (q) begin
                if (model_q.size() == 0) e_u = 1'b1;
                else void'(model_q.pop_back());
            end
            m_ovf = e_o | (m_ovf & ~c);
            m_unf = e_u | (m_unf & ~c);
        end
    endfunction

    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                        input logic c, input logic r);
        push = p; pop = q; din = d; clr_err = c; reset = r;
        @(posedge clk);
        model_update(p, q, d, c, r);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        n_checks++; if (tos !== 16'h0000) begin n_fail++; $display("FAIL reset_tos got %h exp 0000", tos); end
        n_checks++; if (nos !== 16'h0000) begin n_fail++; $display("FAIL reset_nos got %h exp 0000", nos); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err ovf=%b unf=%b exp 0/0", overflow, underflow); end
    endtask

    task automatic test_push_pop;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
        n_checks++; if (tos !== 16'h0003 || nos !== 16'h0002) begin n_fail++; $display("FAIL push3_tos_nos got %h/%h exp 0003/0002", tos, nos); end
        n_checks++; if (count !== 5'd3 || empty !== 1'b0) begin n_fail++; $display("FAIL push3_count got %0d empty=%b exp 3/0", count, empty); end
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (tos !== 16'h0001 || nos !== 16'h0000 || count !== 5'd1) begin n_fail++; $display("FAIL pop2 got tos=%h nos=%h cnt=%0d exp 0001/0000/1", tos, nos, count); end
    endtask

    task automatic test_fill_overflow;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
        n_checks++; if (full !== 1'b1 || tos !== 16'h000F || nos !== 16'h000E) begin n_fail++; $display("FAIL fill got full=%b tos=%h nos=%h exp 1/000f/000e", full, tos, nos); end
        step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        n_checks++; if (tos !== 16'h000F || count !== 5'd16) begin n_fail++; $display("FAIL ovf_hold got tos=%h cnt=%0d exp 000f/16", tos, count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask

    task automatic test_underflow;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (underflow !== 1'b1 || count !== 5'd0 || tos !== 16'h0000) begin n_fail++; $display("FAIL unf got unf=%b cnt=%0d tos=%h exp 1/0/0000", underflow, count, tos); end
    endtask

    task automatic test_empty_replace;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd1 || tos !== 16'hABCD || underflow !== 1'b0) begin n_fail++; $display("FAIL empty_pp got cnt=%0d tos=%h unf=%b exp 1/abcd/0", count, tos, underflow); end
    endtask

    task automatic test_replace;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0042, 1'b0, 1'b0);
        n_checks++; if (tos !== 16'h0042 || nos !== 16'h0005 || count !== 5'd2) begin n_fail++; $display("FAIL replace got tos=%h nos=%h cnt=%0d exp 0042/0005/2", tos, nos, count); end
    endtask

    task automatic test_reset_burst;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h1230 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h7777, 1'b0, 1'b1);
        n_checks++; if (count !== 5'd0 || empty !== 1'b1 || tos !== 16'h0000) begin n_fail++; $display("FAIL rst_burst got cnt=%0d empty=%b tos=%h exp 0/1/0000", count, empty, tos); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rst_burst_err got ovf=%b unf=%b exp 0/0", overflow, underflow); end
    endtask

    task automatic test_set_wins;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b exp 1", underflow); end
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr got %b exp 0", underflow); end
    endtask

    task automatic test_random;
        logic p, q, c, r;
        logic [WIDTH-1:0] d, e_tos, e_nos;
        int sz;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            // Alternate push-heavy and pop-heavy phases so both boundaries are hit.
            if (((i / 60) % 2) == 0) begin
                p = ($urandom_range(99) < 70);
                q = ($urandom_range(99) < 30);
            end else begin
                p = ($urandom_range(99) < 30);
                q = ($urandom_range(99) < 70);
            end
            c = ($urandom_range(99) < 8);
            r = ($urandom_range(99) < 2);
            d = 16'($urandom);
            step(p, q, d, c, r);
            sz = model_q.size();
            e_tos = (sz > 0) ? model_q[sz-1] : 16'h0000;
            e_nos = (sz > 1) ? model_q[sz-2] : 16'h0000;
            n_checks++; if (tos !== e_tos) begin n_fail++; $display("FAIL rnd_tos cyc %0d got %h exp %h", i, tos, e_tos); end
            n_checks++; if (nos !== e_nos) begin n_fail++; $display("FAIL rnd_nos cyc %0d got %h exp %h", i, nos, e_nos); end
            n_checks++; if (count !== 5'(sz)) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, count, sz); end
            n_checks++; if (empty !== (sz == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d got %b exp %b", i, empty, (sz == 0)); end
            n_checks++; if (full !== (sz == DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc %0d got %b exp %b", i, full, (sz == DEPTH)); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", i, overflow, m_ovf); end
            n_checks++; if (underflow !== m_unf) begin n_fail++; $display("FAIL rnd_unf cyc %0d got %b exp %b", i, underflow, m_unf); end
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = 16'h0000; clr_err = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_underflow();
        test_empty_replace();
        test_replace();
        test_reset_burst();
        test_set_wins();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
